fetch_ifid: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register for the 64-bit RISC-V pipeline; sits directly upstream of stall_idex.
- Holds the PC and drives the instruction-memory address. Latches the fetched instruction and its PC for decode.
- Detects load-use hazards and redirects on taken branches resolved in EX.
- Produces the bubble signal that drives stall_idex's stall input, which zeroes ID/EX.

---
 rtl/riscv_pkg.sv | 37 +++
 rtl/fetch_ifid_hazard_detect.sv | 40 ++++
 rtl/fetch_ifid.sv | 110 +++++++++++
 tb/tb_fetch_ifid.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the front end of the pipeline: opcode
// constants, the canonical NOP and helpers that slice instruction fields.
package riscv_pkg;

    // Base-ISA opcodes that the hazard decode must distinguish.
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // addi x0, x0, 0 -- what IF/ID holds when it carries no real instruction.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned ILEN    = 32;
    localparam int unsigned REG_W   = 5;

    // Field slices shared by every decoder in the pipeline.
    function automatic logic [6:0] instr_op(input logic [ILEN-1:0] instr);
        return instr[6:0];
    endfunction

    function automatic logic [REG_W-1:0] instr_rs1(input logic [ILEN-1:0] instr);
        return instr[19:15];
    endfunction

    function automatic logic [REG_W-1:0] instr_rs2(input logic [ILEN-1:0] instr);
        return instr[24:20];
    endfunction

    function automatic logic [REG_W-1:0] instr_rd(input logic [ILEN-1:0] instr);
        return instr[11:7];
    endfunction

endpackage

// File: rtl/fetch_ifid_hazard_detect.sv
// Load-use hazard detector for the instruction sitting in ID. Purely
// combinational: decides which source registers the instruction really reads
// and compares them with the destination of a load currently in EX.
module hazard_detect
    import riscv_pkg::*;
(
    input  logic [6:0]       op,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic             ifid_valid,
    input  logic             idex_mem_read,
    input  logic [REG_W-1:0] idex_rd,
    output logic             uses_rs1,
    output logic             uses_rs2,
    output logic             load_use
);

    logic rs1_hit;
    logic rs2_hit;

    // Source-operand decode: U-type and JAL have no rs1 field, only R/S/B read rs2.
    always_comb begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        if (op == OP_LUI || op == OP_AUIPC || op == OP_JAL) begin
            uses_rs1 = 1'b0;
        end
        if (op == OP_RTYPE || op == OP_STORE || op == OP_BRANCH) begin
            uses_rs2 = 1'b1;
        end
    end

    // Stall only when a real ID instruction reads a non-x0 register a load in EX writes.
    always_comb begin
        rs1_hit  = uses_rs1 && (rs1 == idex_rd);
        rs2_hit  = uses_rs2 && (rs2 == idex_rd);
        load_use = ifid_valid && idex_mem_read && (idex_rd != '0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/fetch_ifid.sv
// Instruction fetch plus the IF/ID pipeline register. Owns the PC, latches
// the fetched word for decode, stalls one cycle on load-use hazards and
// redirects on branches resolved in EX. idex_bubble feeds the ID/EX stall
// input so the EX slot becomes a NOP whenever fetch stalls or flushes.
//
// ifid_valid marks a real instruction in ID; it is cleared on a redirect so
// the flushed slot carries a NOP and never raises a hazard of its own.
module fetch_ifid
    import riscv_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned PC_STEP  = 4,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr_in,
    input  logic             branch_taken,
    input  logic [63:0]      branch_target,
    input  logic             idex_Mem_Read,
    input  logic [4:0]       idex_rd,
    output logic [63:0]      pc_fetch,
    output logic [63:0]      ifid_PC_out,
    output logic [31:0]      ifid_instr_out,
    output logic             ifid_valid,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    logic [63:0]      pc_q,         pc_d;
    logic [63:0]      ifid_pc_q,    ifid_pc_d;
    logic [31:0]      ifid_instr_q, ifid_instr_d;
    logic             ifid_valid_q, ifid_valid_d;
    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q,  flush_cnt_d;

    logic uses_rs1;
    logic uses_rs2;
    logic load_use;

    hazard_detect u_hazard (
        .op            (instr_op(ifid_instr_q)),
        .rs1           (instr_rs1(ifid_instr_q)),
        .rs2           (instr_rs2(ifid_instr_q)),
        .ifid_valid    (ifid_valid_q),
        .idex_mem_read (idex_Mem_Read),
        .idex_rd       (idex_rd),
        .uses_rs1      (uses_rs1),
        .uses_rs2      (uses_rs2),
        .load_use      (load_use)
    );

    // Next-state selection: redirect beats stall beats normal sequential fetch.
    always_comb begin
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (branch_taken) begin
            // Target used as-is; the ID slot is squashed and a pending stall is moot.
            pc_d         = branch_target;
            ifid_pc_d    = '0;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            flush_cnt_d  = flush_cnt_q + CNT_W'(1);
        end else if (load_use) begin
            // Hold PC and IF/ID; the same word is fetched again next cycle.
            stall_cnt_d  = stall_cnt_q + CNT_W'(1);
        end else begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = instr_in;
            ifid_valid_d = 1'b1;
            pc_d         = pc_q + 64'(PC_STEP);
        end
    end

    // State registers; reset discards any in-flight stall or redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    // Output drive; the bubble is same-cycle so ID/EX captures a NOP at this edge.
    always_comb begin
        pc_fetch       = pc_q;
        ifid_PC_out    = ifid_pc_q;
        ifid_instr_out = ifid_instr_q;
        ifid_valid     = ifid_valid_q;
        stall_count    = stall_cnt_q;
        flush_count    = flush_cnt_q;
        idex_bubble    = load_use || branch_taken;
    end

endmodule

// File: tb/tb_fetch_ifid.sv
// Self-checking bench for fetch_ifid: directed scenarios plus a randomized
// run compared against a cycle-level reference model of fetch behaviour.
module tb_fetch_ifid;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_in;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        idex_Mem_Read;
    logic [4:0]  idex_rd;
    logic [63:0] pc_fetch, ifid_PC_out;
    logic [31:0] ifid_instr_out;
    logic        ifid_valid, idex_bubble;
    logic [31:0] stall_count, flush_count;

    logic [63:0] pc_fetch_w, ifid_PC_out_w;
    logic [31:0] ifid_instr_out_w;
    logic        ifid_valid_w, idex_bubble_w;
    logic [31:0] stall_count_w, flush_count_w;

    // instruction source: hashed memory image or a directly forced word
    logic        use_mem;
    logic [31:0] forced_instr;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [63:0] m_pc, m_id_pc;
    logic [31:0] m_id_instr;
    logic        m_id_valid;
    logic [31:0] m_stalls, m_flushes;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [63:0] pc);
        logic [31:0] h;
        logic [4:0]  a, b, d;
        logic [6:0]  op;
        h = pc[31:0] * 32'h9E37_79B1;
        h = h ^ (h >> 15);
        a = {2'b00, h[2:0]};
        b = {2'b00, h[5:3]};
        d = {2'b00, h[8:6]};
        case (h[14:12])
            3'd0:    op = 7'b0110011;
            3'd1:    op = 7'b0010011;
            3'd2:    op = 7'b0000011;
            3'd3:    op = 7'b0100011;
            3'd4:    op = 7'b1100011;
            3'd5:    op = 7'b0110111;
            3'd6:    op = 7'b0010111;
            default: op = 7'b1101111;
        endcase
        return {7'b0, b, a, 3'b0, d, op};
    endfunction

    assign instr_in = use_mem ? imem_word(pc_fetch) : forced_instr;

    fetch_ifid dut (
        .clk(clk), .reset(reset), .instr_in(instr_in),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .idex_Mem_Read(idex_Mem_Read), .idex_rd(idex_rd),
        .pc_fetch(pc_fetch), .ifid_PC_out(ifid_PC_out),
        .ifid_instr_out(ifid_instr_out), .ifid_valid(ifid_valid),
        .idex_bubble(idex_bubble), .stall_count(stall_count),
        .flush_count(flush_count)
    );

    fetch_ifid #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_w (
        .clk(clk), .reset(reset), .instr_in(instr_in),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .idex_Mem_Read(idex_Mem_Read), .idex_rd(idex_rd),
        .pc_fetch(pc_fetch_w), .ifid_PC_out(ifid_PC_out_w),
        .ifid_instr_out(ifid_instr_out_w), .ifid_valid(ifid_valid_w),
        .idex_bubble(idex_bubble_w), .stall_count(stall_count_w),
        .flush_count(flush_count_w)
    );

    // does the instruction read register r as a source operand
    function automatic logic reads_reg(input logic [31:0] ins, input logic [4:0] r);
        logic [6:0] op;
        logic       has_rs1, has_rs2;
        op = ins[6:0];
        has_rs1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
        has_rs2 = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
        return (has_rs1 && ins[19:15] == r) || (has_rs2 && ins[24:20] == r);
    endfunction

    function automatic logic model_load_use();
        return m_id_valid && idex_Mem_Read && idex_rd != 5'd0 && reads_reg(m_id_instr, idex_rd);
    endfunction

    task automatic model_reset();
        m_pc = 64'h0; m_id_pc = 64'h0; m_id_instr = NOP; m_id_valid = 1'b0;
        m_stalls = 0; m_flushes = 0;
    endtask

    // advance one clock and apply the fetch rules to the model
    task automatic tick();
        logic        lu, bt;
        logic [63:0] tgt;
        logic [31:0] ins;
        ins = use_mem ? imem_word(m_pc) : forced_instr;
        lu  = model_load_use();
        bt  = branch_taken;
        tgt = branch_target;
        @(posedge clk);
        if (bt) begin
            m_pc = tgt; m_id_pc = 64'h0; m_id_instr = NOP; m_id_valid = 1'b0;
            m_flushes = m_flushes + 1;
        end else if (lu) begin
            m_stalls = m_stalls + 1;
        end else begin
            m_id_pc = m_pc; m_id_instr = ins; m_id_valid = 1'b1;
            m_pc = m_pc + 64'd4;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; branch_taken = 1'b0; idex_Mem_Read = 1'b0; idex_rd = 5'd0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1; #1;
        checks += 6;
        if (pc_fetch !== 64'h0)          begin errors++; $display("FAIL reset_pc got %h want 0", pc_fetch); end
        if (ifid_PC_out !== 64'h0)       begin errors++; $display("FAIL reset_id_pc got %h want 0", ifid_PC_out); end
        if (ifid_instr_out !== NOP)      begin errors++; $display("FAIL reset_instr got %h want %h", ifid_instr_out, NOP); end
        if (ifid_valid !== 1'b0)         begin errors++; $display("FAIL reset_valid got %b want 0", ifid_valid); end
        if (stall_count !== 0 || flush_count !== 0) begin errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", stall_count, flush_count); end
        if (pc_fetch_w !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL reset_pc_wrapdut got %h want fffffffffffffffc", pc_fetch_w); end
    endtask

    task automatic test_sequential();
        use_mem = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks += 4;
            if (pc_fetch !== 64'(4 * (i + 1))) begin errors++; $display("FAIL seq_pc[%0d] got %h want %h", i, pc_fetch, 64'(4 * (i + 1))); end
            if (ifid_PC_out !== 64'(4 * i))    begin errors++; $display("FAIL seq_id_pc[%0d] got %h want %h", i, ifid_PC_out, 64'(4 * i)); end
            if (ifid_valid !== 1'b1)           begin errors++; $display("FAIL seq_valid[%0d] got %b want 1", i, ifid_valid); end
            if (ifid_instr_out !== imem_word(64'(4 * i))) begin errors++; $display("FAIL seq_instr[%0d] got %h want %h", i, ifid_instr_out, imem_word(64'(4 * i))); end
            if (i == 0) begin
                checks++;
                if (pc_fetch_w !== 64'h0) begin errors++; $display("FAIL pc_wrap got %h want 0", pc_fetch_w); end
            end
        end
    endtask

    task automatic test_load_use();
        logic [63:0] pc_hold;
        do_reset();
        use_mem = 1'b0; forced_instr = 32'h0041_82B3;   // add x5,x3,x4
        tick();
        pc_hold = pc_fetch;
        for (int k = 0; k < 2; k++) begin
            idex_Mem_Read = 1'b1; idex_rd = (k == 0) ? 5'd3 : 5'd4;
            #1;
            checks++;
            if (idex_bubble !== 1'b1) begin errors++; $display("FAIL lu_bubble[%0d] got %b want 1", k, idex_bubble); end
            tick();
            idex_Mem_Read = 1'b0;
            #1;
            checks += 4;
            if (pc_fetch !== pc_hold)          begin errors++; $display("FAIL lu_pc_hold[%0d] got %h want %h", k, pc_fetch, pc_hold); end
            if (ifid_instr_out !== 32'h0041_82B3) begin errors++; $display("FAIL lu_instr_hold[%0d] got %h want 004182b3", k, ifid_instr_out); end
            if (stall_count !== 32'(k + 1))    begin errors++; $display("FAIL lu_stall_count[%0d] got %0d want %0d", k, stall_count, k + 1); end
            if (idex_bubble !== 1'b0)          begin errors++; $display("FAIL lu_release[%0d] got %b want 0", k, idex_bubble); end
        end
        tick();
        checks++;
        if (pc_fetch !== pc_hold + 64'd4) begin errors++; $display("FAIL lu_resume got %h want %h", pc_fetch, pc_hold + 64'd4); end
    endtask

    task automatic test_no_false_stall();
        logic [31:0] s0;
        logic [63:0] p0;
        // load to x0 with add x5,x3,x4 in ID, then LUI x3 (rs1 field 3) against rd=3
        for (int k = 0; k < 2; k++) begin
            forced_instr = (k == 0) ? 32'h0041_82B3 : 32'h0001_81B7;
            idex_Mem_Read = 1'b0;
            tick();
            s0 = m_stalls; p0 = m_pc;
            idex_Mem_Read = 1'b1; idex_rd = (k == 0) ? 5'd0 : 5'd3;
            #1;
            checks++;
            if (idex_bubble !== 1'b0) begin errors++; $display("FAIL nofalse_bubble[%0d] got %b want 0", k, idex_bubble); end
            tick();
            checks += 2;
            if (stall_count !== s0)         begin errors++; $display("FAIL nofalse_count[%0d] got %0d want %0d", k, stall_count, s0); end
            if (pc_fetch !== p0 + 64'd4)    begin errors++; $display("FAIL nofalse_pc[%0d] got %h want %h", k, pc_fetch, p0 + 64'd4); end
        end
        idex_Mem_Read = 1'b0;
    endtask

    task automatic test_branch();
        use_mem = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (pc_fetch !== 64'h20) begin errors++; $display("FAIL br_setup_pc got %h want 20", pc_fetch); end
        branch_taken = 1'b1; branch_target = 64'h100;
        #1;
        checks++;
        if (idex_bubble !== 1'b1) begin errors++; $display("FAIL br_bubble got %b want 1", idex_bubble); end
        tick();
        branch_taken = 1'b0;
        checks += 5;
        if (pc_fetch !== 64'h100)   begin errors++; $display("FAIL br_pc got %h want 100", pc_fetch); end
        if (ifid_instr_out !== NOP) begin errors++; $display("FAIL br_instr got %h want %h", ifid_instr_out, NOP); end
        if (ifid_valid !== 1'b0)    begin errors++; $display("FAIL br_valid got %b want 0", ifid_valid); end
        if (ifid_PC_out !== 64'h0)  begin errors++; $display("FAIL br_id_pc got %h want 0", ifid_PC_out); end
        if (flush_count !== 32'd1)  begin errors++; $display("FAIL br_flush_count got %0d want 1", flush_count); end
    endtask

    task automatic test_branch_and_load_use();
        logic [31:0] s0;
        use_mem = 1'b0; forced_instr = 32'h0041_82B3;
        tick();
        s0 = m_stalls;
        idex_Mem_Read = 1'b1; idex_rd = 5'd3;
        branch_taken = 1'b1; branch_target = 64'h200;
        #1;
        checks++;
        if (idex_bubble !== 1'b1) begin errors++; $display("FAIL brlu_bubble got %b want 1", idex_bubble); end
        tick();
        branch_taken = 1'b0; idex_Mem_Read = 1'b0;
        checks += 4;
        if (pc_fetch !== 64'h200)   begin errors++; $display("FAIL brlu_pc got %h want 200", pc_fetch); end
        if (stall_count !== s0)     begin errors++; $display("FAIL brlu_stall got %0d want %0d", stall_count, s0); end
        if (flush_count !== m_flushes) begin errors++; $display("FAIL brlu_flush got %0d want %0d", flush_count, m_flushes); end
        if (ifid_valid !== 1'b0)    begin errors++; $display("FAIL brlu_valid got %b want 0", ifid_valid); end
    endtask

    task automatic test_async_reset();
        use_mem = 1'b0; forced_instr = 32'h0041_82B3;
        tick();
        tick();
        idex_Mem_Read = 1'b1; idex_rd = 5'd4;
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        checks += 5;
        if (pc_fetch !== 64'h0)     begin errors++; $display("FAIL areset_pc got %h want 0", pc_fetch); end
        if (ifid_valid !== 1'b0)    begin errors++; $display("FAIL areset_valid got %b want 0", ifid_valid); end
        if (ifid_instr_out !== NOP) begin errors++; $display("FAIL areset_instr got %h want %h", ifid_instr_out, NOP); end
        if (stall_count !== 0 || flush_count !== 0) begin errors++; $display("FAIL areset_counts got %0d/%0d want 0/0", stall_count, flush_count); end
        if (idex_bubble !== 1'b0)   begin errors++; $display("FAIL areset_bubble got %b want 0", idex_bubble); end
        idex_Mem_Read = 1'b0;
        do_reset();
    endtask

    task automatic test_random();
        use_mem = 1'b1;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            branch_taken  = ($urandom_range(0, 9) == 0);
            branch_target = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) branch_target = 64'(4 * $urandom_range(0, 64));
            idex_Mem_Read = ($urandom_range(0, 1) == 1);
            idex_rd       = 5'($urandom_range(0, 7));
            #1;
            checks++;
            if (idex_bubble !== (model_load_use() || branch_taken)) begin
                errors++; $display("FAIL rnd_bubble[%0d] got %b want %b", i, idex_bubble, model_load_use() || branch_taken);
            end
            tick();
            checks += 6;
            if (pc_fetch !== m_pc)             begin errors++; $display("FAIL rnd_pc[%0d] got %h want %h", i, pc_fetch, m_pc); end
            if (ifid_PC_out !== m_id_pc)       begin errors++; $display("FAIL rnd_id_pc[%0d] got %h want %h", i, ifid_PC_out, m_id_pc); end
            if (ifid_instr_out !== m_id_instr) begin errors++; $display("FAIL rnd_instr[%0d] got %h want %h", i, ifid_instr_out, m_id_instr); end
            if (ifid_valid !== m_id_valid)     begin errors++; $display("FAIL rnd_valid[%0d] got %b want %b", i, ifid_valid, m_id_valid); end
            if (stall_count !== m_stalls)      begin errors++; $display("FAIL rnd_stalls[%0d] got %0d want %0d", i, stall_count, m_stalls); end
            if (flush_count !== m_flushes)     begin errors++; $display("FAIL rnd_flushes[%0d] got %0d want %0d", i, flush_count, m_flushes); end
        end
        branch_taken = 1'b0; idex_Mem_Read = 1'b0;
    endtask

    initial begin
        reset = 1'b1; branch_taken = 1'b0; branch_target = 64'h0;
        idex_Mem_Read = 1'b0; idex_rd = 5'd0;
        use_mem = 1'b1; forced_instr = NOP;
        model_reset();
        test_reset();
        test_sequential();
        test_load_use();
        test_no_false_stall();
        test_branch();
        test_branch_and_load_use();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
